// File: rtl/syn_branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup on the fetch PC has zero latency; the EX-stage update also reports mispredicts.
module syn_branch_predictor #(
   parameter int AddrBits = 10,
   parameter int Entries  = 16,
   parameter int CntBits  = 2,
   parameter int Mode     = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                flush_tbl,
   input  logic [AddrBits-1:0] lk_pc,
   output logic                lk_taken,
   output logic [AddrBits-1:0] lk_target,
   input  logic                up_valid,
   input  logic [AddrBits-1:0] up_pc,
   input  logic                up_taken,
   input  logic [AddrBits-1:0] up_target,
   input  logic                up_pred_taken,
   input  logic [AddrBits-1:0] up_pred_target,
   output logic                up_mispredict,
   output logic [31:0]         stat_bj,
   output logic [31:0]         stat_miss
);

   localparam int IdxBits = $clog2(Entries);
   localparam int TagBits = AddrBits - IdxBits;
   localparam bit ModeDyn = (Mode != 0);

   // Weak-not-taken sits just below the MSB threshold, weak-taken just above it.
   localparam logic [CntBits-1:0] CntWeakNt = CntBits'((1 << (CntBits - 1)) - 1);
   localparam logic [CntBits-1:0] CntWeakT  = CntBits'(1 << (CntBits - 1));
   localparam logic [CntBits-1:0] CntMax    = {CntBits{1'b1}};

   logic                valid_vec [Entries];
   logic [TagBits-1:0]  tag_vec   [Entries];
   logic [AddrBits-1:0] tgt_vec   [Entries];
   logic [CntBits-1:0]  cnt_vec   [Entries];

   logic [IdxBits-1:0]  lk_idx;
   logic [TagBits-1:0]  lk_tag;
   logic                lk_hit;
   logic [IdxBits-1:0]  up_idx;
   logic [TagBits-1:0]  up_tag;
   logic                up_hit;

   logic                tbl_flush;
   logic                tbl_write;
   logic                stat_inc;

   logic [31:0]         bj_q;
   logic [31:0]         bj_d;
   logic [31:0]         miss_q;
   logic [31:0]         miss_d;

   assign lk_idx = lk_pc[IdxBits-1:0];
   assign lk_tag = lk_pc[AddrBits-1:IdxBits];
   assign up_idx = up_pc[IdxBits-1:0];
   assign up_tag = up_pc[AddrBits-1:IdxBits];

   assign lk_hit = valid_vec[lk_idx] && (tag_vec[lk_idx] == lk_tag);
   assign up_hit = valid_vec[up_idx] && (tag_vec[up_idx] == up_tag);

   // Lookup reads pre-edge contents only; a same-cycle update is not bypassed.
   assign lk_taken  = ModeDyn && lk_hit && cnt_vec[lk_idx][CntBits-1];
   assign lk_target = lk_taken ? tgt_vec[lk_idx] : lk_pc + 1'b1;

   assign up_mispredict = up_valid &&
                          ((up_taken != up_pred_taken) ||
                           (up_taken && (up_target != up_pred_target)));

   // Flush wins over a concurrent update for the table, but the stats still count it.
   assign tbl_flush = en && flush_tbl;
   assign tbl_write = en && up_valid && !flush_tbl;
   assign stat_inc  = en && up_valid;

   genvar gi;
   generate
      for (gi = 0; gi < Entries; gi++) begin : gen_entry
         logic                valid_q;
         logic                valid_d;
         logic [TagBits-1:0]  tag_q;
         logic [TagBits-1:0]  tag_d;
         logic [AddrBits-1:0] tgt_q;
         logic [AddrBits-1:0] tgt_d;
         logic [CntBits-1:0]  cnt_q;
         logic [CntBits-1:0]  cnt_d;
         logic                sel;

         assign sel = tbl_write && (up_idx == IdxBits'(gi));

         always_comb begin
            valid_d = valid_q;
            tag_d   = tag_q;
            tgt_d   = tgt_q;
            cnt_d   = cnt_q;
            if (tbl_flush) begin
               valid_d = 1'b0;
            end else if (sel) begin
               if (up_hit) begin
                  if (up_taken) begin
                     tgt_d = up_target;
                     if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end else if (cnt_q != '0) begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end else if (up_taken) begin
                  // Allocation evicts whatever occupied this slot.
                  valid_d = 1'b1;
                  tag_d   = up_tag;
                  tgt_d   = up_target;
                  cnt_d   = CntWeakT;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_q <= 1'b0;
               tag_q   <= '0;
               tgt_q   <= '0;
               cnt_q   <= CntWeakNt;
            end else begin
               valid_q <= valid_d;
               tag_q   <= tag_d;
               tgt_q   <= tgt_d;
               cnt_q   <= cnt_d;
            end
         end

         assign valid_vec[gi] = valid_q;
         assign tag_vec[gi]   = tag_q;
         assign tgt_vec[gi]   = tgt_q;
         assign cnt_vec[gi]   = cnt_q;
      end
   endgenerate

   always_comb begin
      bj_d   = bj_q;
      miss_d = miss_q;
      if (stat_inc) begin
         bj_d   = bj_q + 32'd1;
         miss_d = miss_q + {31'd0, up_mispredict};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bj_q   <= '0;
         miss_q <= '0;
      end else begin
         bj_q   <= bj_d;
         miss_q <= miss_d;
      end
   end

   assign stat_bj   = bj_q;
   assign stat_miss = miss_q;

endmodule

// File: doc/syn_branch_predictor.md
Name: syn_branch_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters; successor to the 1-bit guess logic in the pipelined core's PC unit.
- Sits beside the PC register in IF.
- IF side: combinational lookup on the fetch PC returns a predicted direction and target.
- EX side: the resolved branch/jump updates the table and reports misprediction for the IF/ID and ID/EX flush.
- Keeps saturating-free event counters for the debug display.

Parameters:
- AddrBits, 10: word-address width of PC and targets; matches IM_ADDR_BIT.
- Entries, 16: table depth. Power of two, 2..256. IdxBits = log2(Entries).
- CntBits, 2: direction counter width, 1..4.
- Mode, 1: 0 = static not-taken (table still updated, never predicts taken); 1 = dynamic.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; when 0, no state changes
- flush_tbl  in  1  synchronous: invalidate all entries
- lk_pc  in  AddrBits  IF fetch word address
- lk_taken  out  1  prediction: redirect fetch
- lk_target  out  AddrBits  predicted next PC; lk_pc+1 when not taken
- up_valid  in  1  EX holds a resolved branch or jump this cycle
- up_pc  in  AddrBits  address of the resolved instruction
- up_taken  in  1  actual direction; jumps drive 1
- up_target  in  AddrBits  actual taken target
- up_pred_taken  in  1  prediction carried down the pipe for this instruction
- up_pred_target  in  AddrBits  predicted target carried down the pipe
- up_mispredict  out  1  combinational; drives pipeline flush and PC correction
- stat_bj  out  32  resolved branch/jump count
- stat_miss  out  32  misprediction count

Behaviour:
- Reset, asynchronous:
  - All valid bits 0; counters set to weak-not-taken, 2^(CntBits-1)-1 (0 when CntBits=1).
  - Tags and targets 0; stat_bj and stat_miss 0.
  - Outputs are combinational from this state: lk_taken=0, lk_target=lk_pc+1.
- Indexing: idx = pc[IdxBits-1:0]; tag = pc[AddrBits-1:IdxBits]. Direct-mapped.
- Lookup, zero latency:
  - hit = valid[idx] && tag match.
  - lk_taken = Mode && hit && counter MSB.
  - lk_target = stored target if lk_taken, else lk_pc+1, mod 2^AddrBits (wraps at top of memory).
- Mispredict:
  - up_mispredict = up_valid && ((up_taken != up_pred_taken) || (up_taken && up_target != up_pred_target)).
  - Forced 0 when up_valid=0.
  - Does not depend on en.
- Update, at the rising edge when en && up_valid:
  - Hit, taken: counter += 1, saturating at 2^CntBits-1; target <= up_target.
  - Hit, not taken: counter -= 1, saturating at 0; target unchanged.
  - Miss, taken: allocate (overwrite any previous occupant). Set valid, write tag and target, counter = weak-taken 2^(CntBits-1).
  - Miss, not taken: no allocation, table unchanged.
  - stat_bj += 1; stat_miss += up_mispredict. Both are 32-bit and wrap modulo 2^32.
- Simultaneous lookup and update to the same idx: the lookup sees pre-edge contents. No bypass.
- flush_tbl && en at an edge:
  - All valid bits cleared; counters and targets are retained but unreachable.
  - Stats are not cleared.
  - Takes priority over a same-cycle update: the update is dropped from the table but still counted in the stats.
- en=0: table and stats hold. Lookup and up_mispredict remain live.
- rst_n asserted mid-operation: immediate clear regardless of clk or en. The first edge after release behaves as post-reset.
- Mode=0: updates and stats proceed identically; lk_taken is always 0.

Test Plan:
1. Reset, then lk_pc=0x010 -> lk_taken=0, lk_target=0x011; stat_bj=0, stat_miss=0.
2. Defaults. Update pc=0x013 taken target=0x040, pred_taken=0 -> up_mispredict=1. Next cycle lookup 0x013 -> lk_taken=1, lk_target=0x040; stat_bj=1, stat_miss=1.
3. Saturation, same entry:
   - Three taken updates -> counter 3.
   - Then four not-taken updates -> counter 0, lk_taken=0.
   - A further not-taken update -> counter stays 0.
   - One taken update -> counter 1, lk_taken still 0.
4. Alias. Allocate pc=0x013; then taken update pc=0x023 (same idx 3) target=0x100 -> lookup 0x013 misses (lk_target=0x014); lookup 0x023 gives 0x100.
5. Same-cycle lookup and update on 0x013 (miss->allocate) -> lk_taken=0 that cycle, 1 the next.
6. Boundaries:
   - flush_tbl with a concurrent update -> all lookups miss; stat_bj still increments.
   - en=0 with up_valid=1 -> no change.
   - lk_pc=0x3FF -> lk_target=0x000.
   - rst_n pulse between edges clears the stats immediately.
